percept_pkt_rx: RTL and testbench

// - Upstream stage of the percept bank: turns the UART receiver's byte stream into validated command packets.
// - Frame: SYNC(0xA5) ADDR CMD LEN PAYLOAD[LEN] CSUM.
// - Buffers the payload, checks the checksum, then streams it to the bank with the packet's addr/cmd.
// - Each percept compares out_addr with its own address. Corrupt or truncated frames never reach the bank.

---
 rtl/percept_pkt_pkg.sv | 20 ++
 rtl/pkt_payload_buf.sv | 29 ++
 rtl/percept_pkt_rx.sv | 199 +++++++++++++++++++
 tb/tb_percept_pkt_rx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/percept_pkt_pkg.sv
// Shared constants and the frame-parser state encoding for the percept packet receiver.
package percept_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_e;

endpackage

// File: rtl/pkt_payload_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
// Written one byte per cycle; no backpressure; read data follows rd_idx in the same cycle.
module pkt_payload_buf #(
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_idx,
  input  logic [7:0]                 wr_dat,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [7:0]                 rd_dat
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] mem_d [MAX_LEN];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_dat;
  end

  // Contents are only read after being written in the same frame, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/percept_pkt_rx.sv
// Frame parser: SYNC ADDR CMD LEN PAYLOAD CSUM -> checked payload beats; pkt_ok/first beat one cycle after CSUM.
// in_ready drops only while draining; PKT_STATS_EN adds saturating ok_cnt/err_cnt outputs.
module percept_pkt_rx
  import percept_pkt_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_addr,
  output logic [7:0]                 out_cmd,
  output logic [$clog2(MAX_LEN)-1:0] out_idx,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  output logic                       pkt_ok,
  output logic                       pkt_err,
  output logic [1:0]                 err_code
`ifdef PKT_STATS_EN
  ,
  output logic [15:0]                ok_cnt,
  output logic [15:0]                err_cnt
`endif
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d, cmd_q, cmd_d, len_q, len_d, sum_q, sum_d;
  logic [IW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ok_q, ok_d, err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          acc, in_frame, last_beat, wr_en;
  logic [7:0]    sum_nx, rd_dat;

  assign in_ready  = (state_q != DRAIN);
  assign acc       = in_valid & in_ready;
  assign in_frame  = state_q inside {ADDR, CMD, LEN, PAYLOAD, CSUM};
  assign sum_nx    = sum_q + in_data;
  assign last_beat = (9'(idx_q) == 9'(len_q) - 9'd1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    timer_d = (in_frame && !acc) ? timer_q + TW'(1) : '0;

    case (state_q)
      IDLE: if (acc && in_data == SYNC_BYTE) begin
        state_d = ADDR;
        sum_d   = '0;
      end
      ADDR: if (acc) begin
        addr_d  = in_data;
        sum_d   = sum_nx;
        state_d = CMD;
      end
      CMD: if (acc) begin
        cmd_d   = in_data;
        sum_d   = sum_nx;
        state_d = LEN;
      end
      LEN: if (acc) begin
        len_d = in_data;
        sum_d = sum_nx;
        cnt_d = '0;
        if (in_data == 8'd0) begin
          state_d = CSUM;
        end else if (32'(in_data) > MAX_LEN) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_LEN;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (acc) begin
        wr_en = 1'b1;
        sum_d = sum_nx;
        cnt_d = cnt_q + IW'(1);
        if (9'(cnt_q) == 9'(len_q) - 9'd1) state_d = CSUM;
      end
      CSUM: if (acc) begin
        if (sum_nx == 8'd0) begin
          ok_d    = 1'b1;
          idx_d   = '0;
          state_d = (len_q == 8'd0) ? IDLE : DRAIN;
        end else begin
          err_d   = 1'b1;
          code_d  = ERR_CSUM;
          state_d = IDLE;
        end
      end
      DRAIN: if (out_ready) begin
        if (last_beat) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted byte on the expiry cycle keeps the frame alive.
    if (in_frame && !acc && timer_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  pkt_payload_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (cnt_q),
    .wr_dat (in_data),
    .rd_idx (idx_q),
    .rd_dat (rd_dat)
  );

  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid & last_beat;
  assign out_data  = out_valid ? rd_dat : 8'd0;
  assign out_idx   = idx_q;
  assign out_addr  = addr_q;
  assign out_cmd   = cmd_q;
  assign pkt_ok    = ok_q;
  assign pkt_err   = err_q;
  assign err_code  = code_q;

`ifdef PKT_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ok_q && ok_cnt_q != 16'hFFFF)   ok_cnt_d  = ok_cnt_q + 16'd1;
    if (err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ok_cnt  = ok_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_percept_pkt_rx.sv
// Bench for percept_pkt_rx: frame-level reference model compared every cycle, directed frames plus random traffic.
module tb_percept_pkt_rx;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, pkt_ok, pkt_err;
  logic [7:0] out_addr, out_cmd, out_data;
  logic [3:0] out_idx;
  logic [1:0] err_code;
`ifdef PKT_STATS_EN
  logic [15:0] ok_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  percept_pkt_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_cmd   (out_cmd),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code)
`ifdef PKT_STATS_EN
    ,
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] d;
    int         idx;
    bit         last;
  } beat_t;

  beat_t      beats[$];   // beats the bank still has to see, front = presented now
  logic [7:0] fr[$];      // bytes of the frame being collected, starting with SYNC
  logic [7:0] tx[$];
  logic [7:0] obs_dat[$];
  int  n_chk = 0, n_fail = 0;
  int  idle = 0, obs_ok = 0, obs_err = 0, mode = 0;
  bit  armed = 1'b0, m_ok = 1'b0, m_err = 1'b0;
  logic [1:0] m_code = 2'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] b;
    bit acc;
    int s, len;
    beat_t bt;
    b   = in_data;
    acc = in_valid && (beats.size() == 0);
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      fr.delete();
      beats.delete();
      m_code = 2'd0;
      idle   = 0;
      armed  = 1'b1;
      return;
    end
    if (beats.size() != 0 && out_ready) void'(beats.pop_front());
    if (acc) begin
      idle = 0;
      if (fr.size() != 0 || b == 8'hA5) fr.push_back(b);
      if (fr.size() == 4 && fr[3] > MAX_LEN) begin
        m_err = 1'b1; m_code = 2'd1; fr.delete();
      end else if (fr.size() >= 5 && fr.size() == 5 + int'(fr[3])) begin
        s = 0;
        for (int i = 1; i < fr.size(); i++) s += int'(fr[i]);
        len = int'(fr[3]);
        if (s % 256 == 0) begin
          m_ok = 1'b1;
          for (int k = 0; k < len; k++) begin
            bt.a = fr[1]; bt.c = fr[2]; bt.d = fr[4+k]; bt.idx = k; bt.last = (k == len - 1);
            beats.push_back(bt);
          end
        end else begin
          m_err = 1'b1; m_code = 2'd2;
        end
        fr.delete();
      end
    end else if (fr.size() != 0) begin
      idle++;
      if (idle == TMO) begin
        m_err = 1'b1; m_code = 2'd3; fr.delete(); idle = 0;
      end
    end
  endtask

  task automatic checker_loop();
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("in_ready", in_ready, beats.size() == 0);
        chk("out_valid", out_valid, beats.size() != 0);
        chk("pkt_ok", pkt_ok, m_ok);
        chk("pkt_err", pkt_err, m_err);
        chk("err_code", err_code, m_code);
        if (beats.size() != 0) begin
          chk("out_addr", out_addr, beats[0].a);
          chk("out_cmd", out_cmd, beats[0].c);
          chk("out_idx", 32'(out_idx), beats[0].idx);
          chk("out_data", out_data, beats[0].d);
          chk("out_last", out_last, beats[0].last);
        end
        if (pkt_ok === 1'b1) obs_ok++;
        if (pkt_err === 1'b1) obs_err++;
        if (out_valid === 1'b1 && out_ready) obs_dat.push_back(out_data);
      end
      model_step();
    end
  endtask

  task automatic ready_loop();
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph % 3 == 0); ph++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic watchdog();
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got running, expected finished");
    $fatal(1, "watchdog");
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 1000; t++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_wait", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_tx(input int gapmax, input int to_pos);
    int g;
    for (int i = 0; i < tx.size(); i++) begin
      g = (i == to_pos) ? TMO + 2 : int'($urandom_range(0, gapmax));
      send_byte(tx[i], g);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int ok0, err0, dat0;
  task automatic snap();
    ok0 = obs_ok; err0 = obs_err; dat0 = obs_dat.size();
  endtask

  initial begin
    int kind, len, pos;
    logic [7:0] s, b;
    fork
      checker_loop();
      ready_loop();
      watchdog();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pkt_ok", pkt_ok, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", out_last, 0);

    // CSUM B8 makes 03+10+02+11+22+CSUM == 0 mod 256.
    snap();
    tx = '{8'hA5, 8'h03, 8'h10, 8'h02, 8'h11, 8'h22, 8'hB8};
    send_tx(0, -1);
    idle_cyc(6);
    chk("f1_ok_count", obs_ok - ok0, 1);
    chk("f1_beats", obs_dat.size() - dat0, 2);
    if (obs_dat.size() >= dat0 + 2) begin
      chk("f1_beat0", obs_dat[dat0], 8'h11);
      chk("f1_beat1", obs_dat[dat0+1], 8'h22);
    end

    snap();
    tx = '{8'hA5, 8'h03, 8'h10, 8'h02, 8'h11, 8'h22, 8'hCB};
    send_tx(0, -1);
    idle_cyc(4);
    chk("badsum_err_count", obs_err - err0, 1);
    chk("badsum_code", err_code, 2);
    chk("badsum_no_beats", obs_dat.size() - dat0, 0);
    tx = '{8'hA5, 8'h03, 8'h10, 8'h02, 8'h11, 8'h22, 8'hB8};
    send_tx(1, -1);
    idle_cyc(6);
    chk("after_bad_ok", obs_ok - ok0, 1);

    snap();
    tx = '{8'hA5, 8'h01, 8'h20, 8'h11, 8'h33, 8'h44, 8'hA5, 8'h05, 8'h01, 8'h00, 8'hFA};
    send_tx(0, -1);
    idle_cyc(4);
    chk("longlen_err_count", obs_err - err0, 1);
    chk("longlen_code", err_code, 1);
    chk("zero_len_ok", obs_ok - ok0, 1);
    chk("zero_len_beats", obs_dat.size() - dat0, 0);

    snap();
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    idle_cyc(TMO + 5);
    chk("timeout_err_count", obs_err - err0, 1);
    chk("timeout_code", err_code, 3);

    snap();
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h10, TMO - 1);
    send_byte(8'h00, 0);
    send_byte(8'hEC, 0);
    idle_cyc(4);
    chk("expiry_byte_no_err", obs_err - err0, 0);
    chk("expiry_byte_ok", obs_ok - ok0, 1);

    snap();
    mode = 1;
    tx = '{8'hA5, 8'h07, 8'h08, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE3,
           8'hA5, 8'h05, 8'h01, 8'h00, 8'hFA};
    send_tx(0, -1);
    idle_cyc(20);
    mode = 0;
    chk("stall_ok_count", obs_ok - ok0, 2);
    chk("stall_beats", obs_dat.size() - dat0, 4);
    if (obs_dat.size() >= dat0 + 4) chk("stall_beat3", obs_dat[dat0+3], 8'h04);

    snap();
    tx = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'hAA, 8'hBB};
    send_tx(0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx = '{8'hA5, 8'h03, 8'h10, 8'h02, 8'h11, 8'h22, 8'hB8};
    send_tx(0, -1);
    idle_cyc(6);
    chk("midrst_ok", obs_ok - ok0, 1);
    chk("midrst_no_err", obs_err - err0, 0);

    mode = 2;
    for (int f = 0; f < 60; f++) begin
      kind = int'($urandom_range(0, 9));
      tx.delete();
      if (kind == 3) tx.push_back(8'h3C);
      len = (kind == 0) ? int'($urandom_range(MAX_LEN + 1, 40)) : int'($urandom_range(0, MAX_LEN));
      tx.push_back(8'hA5);
      tx.push_back(8'($urandom));
      tx.push_back(8'($urandom));
      tx.push_back(8'(len));
      if (kind == 0) begin
        for (int k = 0; k < 3; k++) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          tx.push_back(b);
        end
      end else begin
        for (int k = 0; k < len; k++)
          tx.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
        s = 8'd0;
        for (int k = (kind == 3) ? 2 : 1; k < tx.size(); k++) s = s + tx[k];
        s = 8'd0 - s;
        if (kind == 1) s = s + 8'd1;
        tx.push_back(s);
      end
      pos = (kind == 2) ? int'($urandom_range(1, tx.size() - 1)) : -1;
      send_tx(2, pos);
    end
    mode = 0;
    idle_cyc(TMO + 40);

    snap();
    tx = '{8'hA5, 8'h03, 8'h10, 8'h02, 8'h11, 8'h22, 8'hB8};
    send_tx(0, -1);
    idle_cyc(6);
    chk("final_ok", obs_ok - ok0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
